// File: rtl/beep_pattern_gen.sv
// Buzzer pattern generator: on an accepted trigger, emits N beeps of a square-wave
// tone separated by silent gaps, reporting busy while active and a done pulse at the end.
module beep_pattern_gen #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned TONE_DIV = 25000,
  parameter int unsigned ON_MS    = 100,
  parameter int unsigned OFF_MS   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_trig,
  input  logic [3:0] i_count,
  output logic       o_buzz,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned OnCyc  = ON_MS * TICK_DIV;
  localparam int unsigned OffCyc = OFF_MS * TICK_DIV;
  localparam int unsigned MaxCyc = (OnCyc > OffCyc) ? OnCyc : OffCyc;
  localparam int unsigned PhaseW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned ToneW  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [PhaseW-1:0] OnLast   = PhaseW'(OnCyc - 1);
  localparam logic [PhaseW-1:0] OffLast  = PhaseW'(OffCyc - 1);
  localparam logic [ToneW-1:0]  ToneLast = ToneW'(TONE_DIV - 1);

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e            state_q;
  logic [PhaseW-1:0] phase_q;
  logic [ToneW-1:0]  tone_q;
  logic [3:0]        rem_q;
  logic              buzz_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      tone_q  <= '0;
      rem_q   <= '0;
      buzz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          buzz_q <= 1'b0;
          busy_q <= 1'b0;
          if (i_trig) begin
            rem_q   <= (i_count == 4'd0) ? 4'd1 : i_count;
            phase_q <= '0;
            tone_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StOn;
          end
        end
        StOn: begin
          if (phase_q == OnLast) begin
            // Silence immediately at the end of every beep, whatever the tone phase.
            buzz_q  <= 1'b0;
            phase_q <= '0;
            tone_q  <= '0;
            if (rem_q > 4'd1) begin
              rem_q   <= rem_q - 4'd1;
              state_q <= StGap;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            if (tone_q == ToneLast) begin
              tone_q <= '0;
              buzz_q <= ~buzz_q;
            end else begin
              tone_q <= tone_q + 1'b1;
            end
          end
        end
        StGap: begin
          buzz_q <= 1'b0;
          if (phase_q == OffLast) begin
            phase_q <= '0;
            tone_q  <= '0;
            state_q <= StOn;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: begin
          buzz_q  <= 1'b0;
          busy_q  <= 1'b0;
          phase_q <= '0;
          tone_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_buzz = buzz_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: cycle-by-cycle checks against a timing model plus a
// per-pattern scoreboard of busy length and tone pulse count.
module tb_beep_pattern_gen;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned ToneDiv = 2;
  localparam int unsigned OnMs    = 3;
  localparam int unsigned OffMs   = 2;
  localparam int OnCyc       = OnMs * TickDiv;
  localparam int OffCyc      = OffMs * TickDiv;
  localparam int RisesPerOn  = OnCyc / (2 * ToneDiv);

  logic       clk;
  logic       rst;
  logic       i_trig;
  logic [3:0] i_count;
  logic       o_buzz;
  logic       o_busy;
  logic       o_done;

  beep_pattern_gen #(
    .TICK_DIV (TickDiv),
    .TONE_DIV (ToneDiv),
    .ON_MS    (OnMs),
    .OFF_MS   (OffMs)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_trig  (i_trig),
    .i_count (i_count),
    .o_buzz  (o_buzz),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int rises;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   errors;
  int   checks;
  int   done_cnt;
  int   mon_busy;
  int   mon_rises;
  logic mon_prev;

  // Monitor: measures each completed pattern and hands it to the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy  = 0;
      mon_rises = 0;
      mon_prev  = 1'b0;
    end else begin
      if (o_busy) mon_busy++;
      if (o_buzz && !mon_prev) mon_rises++;
      mon_prev = o_buzz;
      if (o_done) begin
        obs_q.push_back('{mon_busy, mon_rises});
        done_cnt++;
        mon_busy  = 0;
        mon_rises = 0;
      end
    end
  end

  function automatic int total(input int b);
    return b * OnCyc + (b - 1) * OffCyc;
  endfunction

  function automatic logic m_busy(input int k, input int b);
    return (k < total(b)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_done(input int k, input int b);
    return (k == total(b)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_buzz(input int k, input int b);
    int pos;
    if (k >= total(b)) return 1'b0;
    pos = k % (OnCyc + OffCyc);
    if (pos >= OnCyc) return 1'b0;
    return (((pos / ToneDiv) % 2) == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic void push_exp(input logic [3:0] n);
    int b;
    b = (n == 4'd0) ? 1 : int'(n);
    exp_q.push_back('{total(b), b * RisesPerOn});
  endfunction

  // Drives a one-cycle trigger; returns at the first negedge after the accepting edge.
  task automatic fire(input logic [3:0] n);
    @(negedge clk);
    i_trig  = 1'b1;
    i_count = n;
    push_exp(n);
    @(negedge clk);
    i_trig = 1'b0;
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no o_done within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    i_trig  = 1'b0;
    i_count = 4'd0;
    #1;
    checks++;
    if (o_buzz !== 1'b0) begin
      errors++;
      $display("FAIL reset_buzz: got %b required 0", o_buzz);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", o_busy);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0", o_done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_buzz !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy/buzz/done=%b%b%b required 000", o_busy, o_buzz, o_done);
    end
  endtask

  task automatic test_single_beep;
    res_t e, o;
    fire(4'd1);
    for (int k = 0; k <= total(1) + 1; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 1) || o_buzz !== m_buzz(k, 1) || o_done !== m_done(k, 1)) begin
        errors++;
        $display("FAIL single k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                 o_done, m_busy(k, 1), m_buzz(k, 1), m_done(k, 1));
      end
    end
    wait_sb("single", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_single: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy,
                 o.rises, e.busy, e.rises);
      end
    end
  endtask

  task automatic test_two_beeps;
    res_t e, o;
    fire(4'd2);
    for (int k = 0; k <= total(2) + 1; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 2) || o_buzz !== m_buzz(k, 2) || o_done !== m_done(k, 2)) begin
        errors++;
        $display("FAIL two k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                 o_done, m_busy(k, 2), m_buzz(k, 2), m_done(k, 2));
      end
    end
    wait_sb("two", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_two: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy, o.rises,
                 e.busy, e.rises);
      end
    end
  endtask

  task automatic test_zero_count;
    res_t e, o;
    fire(4'd0);
    for (int k = 0; k <= total(1) + 1; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 1) || o_buzz !== m_buzz(k, 1) || o_done !== m_done(k, 1)) begin
        errors++;
        $display("FAIL zero k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                 o_done, m_busy(k, 1), m_buzz(k, 1), m_done(k, 1));
      end
    end
    wait_sb("zero", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_zero: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy, o.rises,
                 e.busy, e.rises);
      end
    end
  endtask

  // Retriggers mid-pattern and on the final busy edge are dropped; one in the done cycle starts.
  task automatic test_back_to_back;
    res_t e, o;
    fire(4'd2);
    for (int k = 0; k <= total(2) + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= total(2)) begin
        checks++;
        if (o_busy !== m_busy(k, 2) || o_buzz !== m_buzz(k, 2) || o_done !== m_done(k, 2)) begin
          errors++;
          $display("FAIL retrig k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                   o_done, m_busy(k, 2), m_buzz(k, 2), m_done(k, 2));
        end
      end else begin
        checks++;
        if (o_busy !== 1'b1 || o_buzz !== 1'b0 || o_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_start: busy/buzz/done=%b%b%b required 100", o_busy, o_buzz, o_done);
        end
      end
      if (k == 4 || k == total(2) - 2) begin
        i_trig  = 1'b1;
        i_count = 4'd5;
      end else if (k == 5) begin
        i_trig = 1'b0;
      end else if (k == total(2)) begin
        i_count = 4'd1;
        push_exp(4'd1);
      end else if (k == total(2) + 1) begin
        i_trig = 1'b0;
      end
    end
    wait_sb("retrig", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_retrig: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy,
                 o.rises, e.busy, e.rises);
      end
    end
    wait_sb("b2b", 40);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_b2b: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy, o.rises,
                 e.busy, e.rises);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra: %0d patterns outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_on;
    res_t e, o;
    int   d0;
    fire(4'd3);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 3) || o_buzz !== m_buzz(k, 3)) begin
        errors++;
        $display("FAIL pre_rst k=%0d: busy/buzz=%b%b required %b%b", k, o_busy, o_buzz,
                 m_busy(k, 3), m_buzz(k, 3));
      end
    end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_buzz !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: busy/buzz/done=%b%b%b required 000", o_busy, o_buzz, o_done);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: done pulses=%0d busy=%b required 0 and 0", done_cnt - d0, o_busy);
    end
    fire(4'd1);
    for (int k = 0; k <= total(1) + 1; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 1) || o_buzz !== m_buzz(k, 1) || o_done !== m_done(k, 1)) begin
        errors++;
        $display("FAIL post_rst k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                 o_done, m_busy(k, 1), m_buzz(k, 1), m_done(k, 1));
      end
    end
    wait_sb("post_rst", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_post_rst: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy,
                 o.rises, e.busy, e.rises);
      end
    end
  endtask

  task automatic test_max_count;
    res_t e, o;
    int   d0;
    d0 = done_cnt;
    fire(4'd15);
    for (int k = 0; k <= total(15) + 1; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (o_busy !== m_busy(k, 15) || o_buzz !== m_buzz(k, 15) || o_done !== m_done(k, 15)) begin
        errors++;
        $display("FAIL max k=%0d: busy/buzz/done=%b%b%b required %b%b%b", k, o_busy, o_buzz,
                 o_done, m_busy(k, 15), m_buzz(k, 15), m_done(k, 15));
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL max_done: done pulses=%0d required 1", done_cnt - d0);
    end
    wait_sb("max", 20);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.busy !== e.busy || o.rises !== e.rises) begin
        errors++;
        $display("FAIL sb_max: busy=%0d rises=%0d required busy=%0d rises=%0d", o.busy, o.rises,
                 e.busy, e.rises);
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    test_reset();
    test_single_beep();
    test_two_beeps();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_on();
    test_max_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/beep_pattern_gen.md
# beep_pattern_gen

Output-side companion to the button input conditioning path. It accepts a single-cycle event pulse, such as a debounced button edge or an alarm/timer expiry, and drives a piezo buzzer pin. The output is a patterned tone: N beeps of a square-wave tone, separated by silent gaps. The block sits between the watch control FSM and the board buzzer pin, and reports busy/done back to the controller.

## Interface
- TICK_DIV, 100000, clk cycles per 1 ms timebase tick (100 MHz clk)
- TONE_DIV, 25000, clk cycles per tone half-period (2 kHz tone at 100 MHz)
- ON_MS, 100, beep duration in ticks
- OFF_MS, 100, gap between beeps in ticks
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- i_trig  input  1  single-cycle request pulse
- i_count  input  4  number of beeps, sampled on accepted trigger; 0 is treated as 1
- o_buzz  output  1  registered tone output to the buzzer
- o_busy  output  1  registered; high while a pattern is in progress
- o_done  output  1  registered single-cycle pulse at pattern end

## Operation
- FSM states: IDLE, ON, GAP.
- IDLE: o_buzz=0, o_busy=0. When i_trig=1:
  - latch the beep count into a remaining counter (0→1);
  - go to ON;
  - clear the phase counter and the tone counter.
- i_trig while o_busy=1 is ignored. There is no queueing and the latched count is not modified.
- Phase counter:
  - counts clk cycles;
  - ON lasts exactly ON_MS*TICK_DIV cycles;
  - GAP lasts exactly OFF_MS*TICK_DIV cycles;
  - width is $clog2(max(ON_MS,OFF_MS)*TICK_DIV).
- Tone counter:
  - active only in ON;
  - o_buzz toggles when the counter reaches TONE_DIV-1, then the counter wraps to 0;
  - o_buzz starts each ON phase at 0;
  - o_buzz is forced to 0 in GAP and IDLE.
- End of ON, more than one beep remaining: decrement the remaining counter and go to GAP.
- End of ON, last beep: go to IDLE and assert o_done for one cycle. There is no trailing gap.
- End of GAP: go to ON and clear the tone counter.
- Beep count arithmetic: 4-bit unsigned, maximum 15 beeps. The remaining counter never wraps below 1.

## Timing
- Reset values: o_buzz=0, o_busy=0, o_done=0, state IDLE, all counters 0.
- rst asserted mid-pattern aborts immediately. Outputs return to reset values asynchronously and the in-progress pattern is discarded.
- Latency: trigger sampled at edge E0 → o_busy=1 and state ON from E0.
- Total busy time: N*ON_MS*TICK_DIV + (N-1)*OFF_MS*TICK_DIV cycles.
- Deassertion at end of pattern: o_busy falls and o_done rises at the same edge, and o_done falls one edge later.
- Back-to-back requests:
  - a trigger in the o_done cycle is accepted, since o_busy=0 in that cycle;
  - the new pattern starts at the next edge.
- Simultaneous trigger and end-of-pattern edge: a trigger in the last busy cycle is ignored.
- o_buzz is glitch-free (driven directly from a flop).

## Test plan
Directed scenarios use TICK_DIV=4, TONE_DIV=2, ON_MS=3, OFF_MS=2, so ON=12 cycles and GAP=8 cycles.
- Single beep: i_count=1 pulse at E0 → o_busy high for 12 cycles. o_buzz shows 3 high pulses of 2 cycles, first rising at E2. o_done is high for one cycle after E12, then idle.
- Two beeps: i_count=2 → o_busy high for 32 cycles, o_buzz silent during E12–E20, o_done pulses once after E32.
- Zero count: i_count=0 → identical behaviour to i_count=1.
- Ignored retrigger: i_count=2 at E0, then i_trig with i_count=5 at E5 and at E31 → pattern still ends after E32 with 2 beeps. A trigger in the o_done cycle starts a new pattern at the next edge.
- Reset mid-ON: assert rst at E7 of a 3-beep pattern → o_buzz=0 and o_busy=0 immediately, no o_done. The first trigger after release behaves like a fresh start.
- Max count: i_count=15 → 15 beeps, busy for 15*12+14*8=292 cycles, exactly one o_done.
